gc_refresh_rotator: RTL and testbench

Bank-rotation refresh controller for the three-bank gain-cell memory array built from MEM_WRAPPER instances, ring-connected so that bank k+1 refreshes from bank k. It is the initiator side of the wrapper's refresh/user-strobe interface and replaces the hand-driven sequencing used in bench work. It owns three things:
- which bank holds live data;
- when a refresh copy starts and ends;
- onto which bank's strobes each user read/write is steered.

---
 rtl/gc_mem_pkg.sv | 24 ++
 rtl/gc_refresh_rotator_if.sv | 37 +++
 rtl/gc_ref_timer.sv | 41 ++++
 rtl/gc_refresh_rotator.sv | 149 ++++++++++++++
 tb/tb_gc_refresh_rotator.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/gc_mem_pkg.sv
// Shared types and helpers for the three-bank gain-cell refresh rotator.
package gc_mem_pkg;

  localparam int unsigned NUM_BANKS = 3;

  typedef logic [1:0] bank_idx_t;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_START = 2'd1,
    ST_COPY  = 2'd2,
    ST_SWAP  = 2'd3
  } state_e;

  // Ring successor: bank k+1 refreshes from bank k, 2 wraps to 0.
  function automatic bank_idx_t next_bank(bank_idx_t b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

  function automatic logic [NUM_BANKS-1:0] bank_mask(bank_idx_t b);
    return NUM_BANKS'(1) << b;
  endfunction

endpackage

// File: rtl/gc_refresh_rotator_if.sv
// User-strobe / refresh bus between the rotator (master) and the bank wrappers plus user (slave).
// ref_timeout exists only when GC_REF_DONE_HANDSHAKE_EN is defined.
interface gc_refresh_rotator_if;
  import gc_mem_pkg::*;

  logic                 usr_we;
  logic                 usr_re;
  logic                 ref_req;
  logic [NUM_BANKS-1:0] ref_done;
  logic [NUM_BANKS-1:0] u_we;
  logic [NUM_BANKS-1:0] u_re;
  logic [NUM_BANKS-1:0] ref_en;
  logic [NUM_BANKS-1:0] start_sr;
  bank_idx_t            rd_sel;
  logic                 rvalid;
  bank_idx_t            active;
  logic                 refreshing;
`ifdef GC_REF_DONE_HANDSHAKE_EN
  logic                 ref_timeout;
`endif

  modport master (
    input  usr_we, usr_re, ref_req, ref_done,
    output u_we, u_re, ref_en, start_sr, rd_sel, rvalid, active, refreshing
`ifdef GC_REF_DONE_HANDSHAKE_EN
    , output ref_timeout
`endif
  );

  modport slave (
    output usr_we, usr_re, ref_req, ref_done,
    input  u_we, u_re, ref_en, start_sr, rd_sel, rvalid, active, refreshing
`ifdef GC_REF_DONE_HANDSHAKE_EN
    , input ref_timeout
`endif
  );
endinterface

// File: rtl/gc_ref_timer.sv
// Retention counter and copy counter for the refresh rotator.
module gc_ref_timer #(
  parameter int unsigned RET_W = 10,
  parameter int unsigned CPY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ret_inc,
  input  logic             ret_clr,
  input  logic             cpy_load,
  input  logic             cpy_inc,
  output logic [RET_W-1:0] ret_cnt,
  output logic [CPY_W-1:0] cpy_cnt
);

  logic [RET_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [CPY_W-1:0] cpy_cnt_q, cpy_cnt_d;

  always_comb begin
    ret_cnt_d = ret_cnt_q;
    cpy_cnt_d = cpy_cnt_q;
    if (ret_clr)      ret_cnt_d = '0;
    else if (ret_inc) ret_cnt_d = ret_cnt_q + RET_W'(1);
    if (cpy_load)     cpy_cnt_d = '0;
    else if (cpy_inc) cpy_cnt_d = cpy_cnt_q + CPY_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_cnt_q <= '0;
      cpy_cnt_q <= '0;
    end else begin
      ret_cnt_q <= ret_cnt_d;
      cpy_cnt_q <= cpy_cnt_d;
    end
  end

  assign ret_cnt = ret_cnt_q;
  assign cpy_cnt = cpy_cnt_q;

endmodule

// File: rtl/gc_refresh_rotator.sv
// Bank-rotation refresh controller: FSM, user strobe steering and read select.
// Optional GC_REF_DONE_HANDSHAKE_EN: copy ends on ref_done[d], with timeout and ref_timeout.
module gc_refresh_rotator
  import gc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned RET_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  gc_refresh_rotator_if.master bus
);

  localparam int unsigned RET_W = $clog2(RET_CYCLES);
  // One extra bit beyond the address so the counter can reach 2*DEPTH-1.
  localparam int unsigned CPY_W = ADDR_W + 1;

  state_e    state_q, state_d;
  bank_idx_t active_q, active_d;
  bank_idx_t rd_sel_q, rd_sel_d;
  logic      rvalid_q, rvalid_d;
  logic      pend_q, pend_d;
  logic      ret_inc, ret_clr, cpy_load, cpy_inc;
  logic      copy_done;
  bank_idx_t src, dst, tgt;
  logic [RET_W-1:0] ret_cnt;
  logic [CPY_W-1:0] cpy_cnt;

  assign src = active_q;
  assign dst = next_bank(active_q);

`ifdef GC_REF_DONE_HANDSHAKE_EN
  logic timeout_q, timeout_d;
  logic cpy_expired;
  assign cpy_expired = (cpy_cnt == CPY_W'(2 * DEPTH - 1));
  assign copy_done   = bus.ref_done[dst] || cpy_expired;
  assign bus.ref_timeout = timeout_q;
`else
  logic ref_done_unused;
  assign ref_done_unused = ^bus.ref_done;
  assign copy_done = (cpy_cnt == CPY_W'(DEPTH));
`endif

  gc_ref_timer #(
    .RET_W (RET_W),
    .CPY_W (CPY_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .ret_inc  (ret_inc),
    .ret_clr  (ret_clr),
    .cpy_load (cpy_load),
    .cpy_inc  (cpy_inc),
    .ret_cnt  (ret_cnt),
    .cpy_cnt  (cpy_cnt)
  );

  // Next-state, counter controls and per-bank strobes.
  always_comb begin
    state_d        = state_q;
    active_d       = active_q;
    pend_d         = pend_q;
    ret_inc        = 1'b0;
    ret_clr        = 1'b0;
    cpy_load       = 1'b0;
    cpy_inc        = 1'b0;
    tgt            = active_q;
    bus.ref_en     = '0;
    bus.start_sr   = '0;
    bus.refreshing = 1'b0;
`ifdef GC_REF_DONE_HANDSHAKE_EN
    timeout_d      = timeout_q;
`endif
    unique case (state_q)
      ST_HOLD: begin
        if ((ret_cnt == RET_W'(RET_CYCLES - 1)) || bus.ref_req || pend_q) begin
          state_d = ST_START;
          ret_clr = 1'b1;
          pend_d  = 1'b0;
        end else begin
          ret_inc = 1'b1;
        end
      end
      ST_START: begin
        bus.ref_en     = bank_mask(src);
        bus.start_sr   = bank_mask(src);
        bus.refreshing = 1'b1;
        cpy_load       = 1'b1;
        state_d        = ST_COPY;
        if (bus.ref_req) pend_d = 1'b1;
      end
      ST_COPY: begin
        bus.ref_en     = bank_mask(src);
        bus.refreshing = 1'b1;
        cpy_inc        = 1'b1;
        if (bus.ref_req) pend_d = 1'b1;
        if (copy_done) state_d = ST_SWAP;
`ifdef GC_REF_DONE_HANDSHAKE_EN
        if (cpy_expired && !bus.ref_done[dst]) timeout_d = 1'b1;
`endif
      end
      ST_SWAP: begin
        active_d = dst;
        tgt      = dst;
        state_d  = ST_HOLD;
        if (bus.ref_req) pend_d = 1'b1;
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // Zero-latency steering; reads during a copy come back from the destination.
  always_comb begin
    bus.u_we = bus.usr_we ? bank_mask(tgt) : '0;
    bus.u_re = bus.usr_re ? bank_mask(tgt) : '0;
    rd_sel_d = rd_sel_q;
    if (bus.usr_re)
      rd_sel_d = ((state_q == ST_START) || (state_q == ST_COPY)) ? dst : tgt;
    rvalid_d = bus.usr_re;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HOLD;
      active_q  <= 2'd0;
      rd_sel_q  <= 2'd0;
      rvalid_q  <= 1'b0;
      pend_q    <= 1'b0;
`ifdef GC_REF_DONE_HANDSHAKE_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      rd_sel_q  <= rd_sel_d;
      rvalid_q  <= rvalid_d;
      pend_q    <= pend_d;
`ifdef GC_REF_DONE_HANDSHAKE_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.active = active_q;
  assign bus.rd_sel = rd_sel_q;
  assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_gc_refresh_rotator.sv
// Directed bench for gc_refresh_rotator with RET_CYCLES=16, DEPTH=128.
module tb_gc_refresh_rotator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   n;

  always #5 clk = ~clk;

  gc_refresh_rotator_if bus ();

  gc_refresh_rotator #(
    .ADDR_W     (7),
    .DEPTH      (128),
    .RET_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_start(output int cnt);
    cnt = 0;
    while (bus.start_sr == 3'b000 && cnt < 300) begin
      step();
      cnt++;
    end
  endtask

  task automatic wait_swap();
    int k = 0;
    while (bus.refreshing && k < 600) begin
      step();
      k++;
    end
    chk("swap_reached", 32'(bus.refreshing), 0);
  endtask

  initial begin
    bus.usr_we  = 1'b0;
    bus.usr_re  = 1'b0;
    bus.ref_req = 1'b0;
`ifdef GC_REF_DONE_HANDSHAKE_EN
    bus.ref_done = 3'b000;
    do_reset();
    chk("rst_timeout", 32'(bus.ref_timeout), 0);
    wait_start(n);
    chk("hs_start_wait", n, 16);
    chk("hs_start_sr", 32'(bus.start_sr), 1);
    step();
    n = 0;
    while (bus.refreshing && n < 600) begin
      step();
      n++;
    end
    chk("hs_copy_len", n, 256);
    chk("hs_timeout", 32'(bus.ref_timeout), 1);
    step();
    chk("hs_active", 32'(bus.active), 1);
    chk("hs_timeout_sticky", 32'(bus.ref_timeout), 1);
`else
    bus.ref_done = 3'b111;
    do_reset();
    chk("rst_active", 32'(bus.active), 0);
    chk("rst_refreshing", 32'(bus.refreshing), 0);
    chk("rst_ref_en", 32'(bus.ref_en), 0);
    chk("rst_start_sr", 32'(bus.start_sr), 0);
    chk("rst_rd_sel", 32'(bus.rd_sel), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_u_we", 32'(bus.u_we), 0);
    repeat (15) step();
    chk("c15_start_sr", 32'(bus.start_sr), 0);
    step();
    chk("c16_start_sr", 32'(bus.start_sr), 1);
    chk("c16_ref_en", 32'(bus.ref_en), 1);
    chk("c16_refreshing", 32'(bus.refreshing), 1);

    // Count ref_en[0] cycles, with a write at COPY 50 and a read at COPY 70.
    n = 0;
    while (bus.ref_en == 3'b001 && n < 400) begin
      if (n == 1) chk("copy_start_sr", 32'(bus.start_sr), 0);
      if (n == 51) begin
        bus.usr_we = 1'b1;
        #1;
        chk("copy_we", 32'(bus.u_we), 1);
        chk("copy_we_no_re", 32'(bus.u_re), 0);
      end
      if (n == 71) begin
        bus.usr_re = 1'b1;
        #1;
        chk("copy_re", 32'(bus.u_re), 1);
      end
      if (n == 72) begin
        chk("copy_rd_sel", 32'(bus.rd_sel), 1);
        chk("copy_rvalid", 32'(bus.rvalid), 1);
      end
      step();
      bus.usr_we = 1'b0;
      bus.usr_re = 1'b0;
      n++;
    end
    chk("ref_en_len", n, 130);
    chk("swap_ref_en", 32'(bus.ref_en), 0);
    chk("swap_active", 32'(bus.active), 0);
    bus.usr_we = 1'b1;
    #1;
    chk("swap_we", 32'(bus.u_we), 2);
    step();
    bus.usr_we = 1'b0;
    chk("hold_active1", 32'(bus.active), 1);
    bus.usr_re = 1'b1;
    #1;
    chk("hold_re", 32'(bus.u_re), 2);
    step();
    bus.usr_re = 1'b0;
    chk("hold_rd_sel", 32'(bus.rd_sel), 1);
    chk("hold_rvalid", 32'(bus.rvalid), 1);
    step();
    chk("hold_rvalid_drop", 32'(bus.rvalid), 0);

    wait_start(n);
    chk("r2_wait", n, 14);
    chk("r2_start_sr", 32'(bus.start_sr), 2);
    wait_swap();
    step();
    chk("r2_active", 32'(bus.active), 2);
    bus.usr_re = 1'b1;
    #1;
    chk("r2_re", 32'(bus.u_re), 4);
    step();
    bus.usr_re = 1'b0;
    chk("r2_rd_sel", 32'(bus.rd_sel), 2);

    wait_start(n);
    chk("r3_wait", n, 15);
    chk("r3_start_sr", 32'(bus.start_sr), 4);
    wait_swap();
    step();
    chk("r3_active", 32'(bus.active), 0);

    // Two requests during COPY collapse into one extra refresh.
    wait_start(n);
    chk("r4_wait", n, 16);
    chk("r4_start_sr", 32'(bus.start_sr), 1);
    repeat (10) step();
    bus.ref_req = 1'b1;
    step();
    bus.ref_req = 1'b0;
    repeat (5) step();
    bus.ref_req = 1'b1;
    step();
    bus.ref_req = 1'b0;
    wait_swap();
    step();
    chk("r4_active", 32'(bus.active), 1);
    chk("r4_hold_start_sr", 32'(bus.start_sr), 0);
    step();
    chk("r5_start_sr", 32'(bus.start_sr), 2);
    wait_swap();
    step();
    chk("r5_active", 32'(bus.active), 2);
    wait_start(n);
    chk("r6_wait", n, 16);
    chk("r6_start_sr", 32'(bus.start_sr), 4);

    // Reset at COPY cycle 60 abandons the copy.
    repeat (61) step();
    chk("c60_ref_en", 32'(bus.ref_en), 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ref_en", 32'(bus.ref_en), 0);
    chk("mid_rst_start_sr", 32'(bus.start_sr), 0);
    chk("mid_rst_u_we", 32'(bus.u_we), 0);
    chk("mid_rst_u_re", 32'(bus.u_re), 0);
    chk("mid_rst_active", 32'(bus.active), 0);
    chk("mid_rst_refreshing", 32'(bus.refreshing), 0);
    chk("mid_rst_rd_sel", 32'(bus.rd_sel), 0);

    // Request in HOLD: start_sr one cycle later.
    repeat (3) step();
    chk("req_pre_start_sr", 32'(bus.start_sr), 0);
    bus.ref_req = 1'b1;
    step();
    bus.ref_req = 1'b0;
    chk("req_start_sr", 32'(bus.start_sr), 1);
    chk("req_ref_en", 32'(bus.ref_en), 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
